// File: rtl/edge_delay_line.sv
// edge_delay_line: delays one colour-channel bitstream by a whole-waveform
// delay W and adds extra delay R to rising edges and F to falling edges.
// A change of any delay value blanks the output while the history refills.
//
// Edge shaping works on the tap window between nR = W+R and nF = W+F.
// When R >= F, the output is high only if every tap in [nF..nR] is high.
// A high pulse is therefore shortened by R-F, and it is removed when
// P <= R-F. When R < F, the output is high if any tap in [nR..nF] is high.
// Pulses are stretched by F-R, and low gaps shorter than F-R are filled.
// Two register stages follow the history (shape register, output register).
// A rising edge therefore appears 2+W+R edges after it is sampled, and a
// falling edge appears 2+W+F edges after it is sampled.
module edge_delay_line #(
  parameter int DELAY_WIDTH = 4
) (
  input  logic                   clk_x10,
  input  logic                   g_rst,
  input  logic                   data_in,
  input  logic                   inverse,
  input  logic [DELAY_WIDTH-1:0] whole_delay_value,
  input  logic [DELAY_WIDTH-1:0] rising_delay_value,
  input  logic [DELAY_WIDTH-1:0] falling_delay_value,
  output logic                   data_out,
  output logic                   settling
);

  localparam int MAX_TAP  = 2 * ((1 << DELAY_WIDTH) - 1);
  localparam int HIST_LEN = MAX_TAP + 1;
  localparam int TAP_W    = DELAY_WIDTH + 1;
  localparam int CNT_W    = $clog2(MAX_TAP + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MAX_TAP);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  logic [HIST_LEN-1:0]    r_hist;
  logic [DELAY_WIDTH-1:0] r_whole;
  logic [DELAY_WIDTH-1:0] r_rise;
  logic [DELAY_WIDTH-1:0] r_fall;
  logic [CNT_W-1:0]       r_count;
  logic [0:0]             r_state;
  logic                   r_shape;
  logic                   r_data_out;

  logic [TAP_W-1:0] w_tap_rise;
  logic [TAP_W-1:0] w_tap_fall;
  logic [TAP_W-1:0] w_lo;
  logic [TAP_W-1:0] w_hi;
  logic             w_rise_dominant;
  logic             w_win_and;
  logic             w_win_or;
  logic             w_shape;
  logic             w_change;
  logic [0:0]       w_next_state;

  // Tap positions are one bit wider than the delays, so the sum never wraps.
  assign w_tap_rise      = {1'b0, r_whole} + {1'b0, r_rise};
  assign w_tap_fall      = {1'b0, r_whole} + {1'b0, r_fall};
  assign w_rise_dominant = (r_rise >= r_fall);
  assign w_lo            = w_rise_dominant ? w_tap_fall : w_tap_rise;
  assign w_hi            = w_rise_dominant ? w_tap_rise : w_tap_fall;

  assign w_change = (whole_delay_value   != r_whole) ||
                    (rising_delay_value  != r_rise)  ||
                    (falling_delay_value != r_fall);

  // AND and OR reductions over the history taps inside [w_lo..w_hi]
  always_comb begin
    w_win_and = 1'b1;
    w_win_or  = 1'b0;
    for (int k = 0; k < HIST_LEN; k++) begin
      if ((TAP_W'(k) >= w_lo) && (TAP_W'(k) <= w_hi)) begin
        w_win_and = w_win_and & r_hist[k];
        w_win_or  = w_win_or  | r_hist[k];
      end
    end
  end

  assign w_shape = w_rise_dominant ? w_win_and : w_win_or;

  // Next state: a delay change always (re)enters SETTLE; an expired count returns to RUN
  always_comb begin
    w_next_state = r_state;
    if (w_change) begin
      w_next_state = ST_SETTLE;
    end else if ((r_state == ST_SETTLE) && (r_count == '0)) begin
      w_next_state = ST_RUN;
    end
  end

  // History shifts every edge, whatever the state
  always_ff @(posedge clk_x10 or posedge g_rst) begin
    if (g_rst) begin
      r_hist <= '0;
    end else begin
      r_hist <= {r_hist[HIST_LEN-2:0], data_in};
    end
  end

  // Active delay values, state and settle counter
  always_ff @(posedge clk_x10 or posedge g_rst) begin
    if (g_rst) begin
      r_whole <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_count <= '0;
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
      if (w_change) begin
        r_whole <= whole_delay_value;
        r_rise  <= rising_delay_value;
        r_fall  <= falling_delay_value;
        r_count <= CNT_RELOAD;
      end else if ((r_state == ST_SETTLE) && (r_count != '0)) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Shaped value, then output with polarity; blanked to idle level while settling
  always_ff @(posedge clk_x10 or posedge g_rst) begin
    if (g_rst) begin
      r_shape    <= 1'b0;
      r_data_out <= 1'b0;
    end else begin
      r_shape    <= w_shape;
      r_data_out <= (w_next_state == ST_RUN) ? (r_shape ^ inverse) : inverse;
    end
  end

  assign data_out = r_data_out;
  assign settling = (r_state == ST_SETTLE);

endmodule

// File: tb/tb_edge_delay_line.sv
// Bench for edge_delay_line: directed vector table, hand-written settle,
// inverse and reset sequences, and a random phase. Every edge is also
// checked against a reference model that works on sampled bit history.
module tb_edge_delay_line;

  logic       clk_x10;
  logic       g_rst;
  logic       data_in;
  logic       inverse;
  logic [3:0] whole_delay_value;
  logic [3:0] rising_delay_value;
  logic [3:0] falling_delay_value;
  logic       data_out;
  logic       settling;

  int checks   = 0;
  int failures = 0;

  edge_delay_line #(.DELAY_WIDTH(4)) dut (
    .clk_x10             (clk_x10),
    .g_rst               (g_rst),
    .data_in             (data_in),
    .inverse             (inverse),
    .whole_delay_value   (whole_delay_value),
    .rising_delay_value  (rising_delay_value),
    .falling_delay_value (falling_delay_value),
    .data_out            (data_out),
    .settling            (settling)
  );

  // clock / reset block
  initial clk_x10 = 1'b0;
  always #5 clk_x10 = ~clk_x10;

  // ---------------- reference model ----------------
  // Sampled input bits, newest at index 0; missing entries read as 0.
  logic       hist_q[$];
  int         m_w, m_r, m_f;
  int         last_change;
  int         cyc;
  logic       exp_out;
  logic       exp_set;

  function automatic logic hbit(int i);
    if (i < hist_q.size()) return hist_q[i];
    return 1'b0;
  endfunction

  // Shaped level seen two edges after sampling, from the tap window rules
  function automatic logic window_val();
    int  n_r, n_f;
    logic v;
    n_r = m_w + m_r;
    n_f = m_w + m_f;
    if (m_r >= m_f) begin
      v = 1'b1;
      for (int k = n_f; k <= n_r; k++) if (hbit(2 + k) == 1'b0) v = 1'b0;
    end else begin
      v = 1'b0;
      for (int k = n_r; k <= n_f; k++) if (hbit(2 + k) == 1'b1) v = 1'b1;
    end
    return v;
  endfunction

  task automatic model_reset();
    hist_q.delete();
    m_w = 0; m_r = 0; m_f = 0;
    last_change = -1000;
    exp_out = 1'b0;
    exp_set = 1'b0;
  endtask

  task automatic model_edge();
    if (g_rst) begin
      model_reset();
    end else begin
      hist_q.push_front(data_in);
      if (hist_q.size() > 40) void'(hist_q.pop_back());
      if (int'(whole_delay_value) != m_w || int'(rising_delay_value) != m_r ||
          int'(falling_delay_value) != m_f) begin
        m_w = int'(whole_delay_value);
        m_r = int'(rising_delay_value);
        m_f = int'(falling_delay_value);
        last_change = cyc;
      end
      exp_set = ((cyc - last_change) <= 30);
      exp_out = exp_set ? inverse : (window_val() ^ inverse);
    end
    cyc++;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge: model follows the edge, outputs sampled 1 time unit later
  task automatic cycle();
    @(posedge clk_x10);
    model_edge();
    #1;
    check_bit("model_data_out", data_out, exp_out);
    check_bit("model_settling", settling, exp_set);
  endtask

  task automatic set_delays(int w, int r, int f);
    whole_delay_value   = 4'(w);
    rising_delay_value  = 4'(r);
    falling_delay_value = 4'(f);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  w;
    logic [3:0]  r;
    logic [3:0]  f;
    logic [15:0] pat;  // bit i is data_in at edge i
    logic [23:0] exp;  // bit j is data_out after edge j
    string       name;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cnt;
    int blank_bad;
    logic [23:0] got;

    vecs[0] = '{4'd3, 4'd0, 4'd0, 16'h0001, 24'h000020, "w3_pulse1"};
    vecs[1] = '{4'd0, 4'd2, 4'd0, 16'h003F, 24'h0000F0, "r2_pulse6"};
    vecs[2] = '{4'd0, 4'd5, 4'd0, 16'h0007, 24'h000000, "r5_pulse3_suppressed"};
    vecs[3] = '{4'd0, 4'd0, 4'd3, 16'h000F, 24'h0001FC, "f3_pulse4"};
    vecs[4] = '{4'd0, 4'd0, 4'd3, 16'h001B, 24'h0003FC, "f3_gap_filled"};
    vecs[5] = '{4'd2, 4'd1, 4'd1, 16'h0007, 24'h0000E0, "w2r1f1_pulse3"};

    cyc = 0;
    model_reset();
    g_rst   = 1'b1;
    data_in = 1'b0;
    inverse = 1'b0;
    set_delays(0, 0, 0);

    // reset state before any clock edge
    #1;
    check_bit("reset_data_out", data_out, 1'b0);
    check_bit("reset_settling", settling, 1'b0);
    repeat (3) cycle();
    g_rst = 1'b0;
    repeat (5) cycle();

    // nonzero delays right after release: first edge enters settle at idle level
    g_rst = 1'b1;
    cycle();
    inverse = 1'b1;
    set_delays(2, 1, 0);
    g_rst = 1'b0;
    cycle();
    check_bit("release_settling", settling, 1'b1);
    check_bit("release_idle_level", data_out, 1'b1);
    inverse = 1'b0;
    set_delays(0, 0, 0);
    repeat (40) cycle();

    // delay change in RUN: 31 cycles of settling at idle level
    cnt = 0; blank_bad = 0;
    set_delays(0, 1, 0);
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (!settling) break;
      cnt++;
      if (data_out !== inverse) blank_bad++;
    end
    check_int("settle_len_31", cnt, 31);
    check_int("settle_blank_inv0", blank_bad, 0);

    // inverse=1, change then a second change after 10 settle cycles: 41 total
    inverse = 1'b1;
    repeat (3) cycle();
    cnt = 0; blank_bad = 0;
    set_delays(0, 2, 0);
    for (int i = 0; i < 100; i++) begin
      if (cnt == 10) set_delays(0, 3, 0);
      cycle();
      if (!settling) break;
      cnt++;
      if (data_out !== 1'b1) blank_bad++;
    end
    check_int("settle_len_restart_41", cnt, 41);
    check_int("settle_blank_inv1", blank_bad, 0);

    // inverse toggle in RUN takes effect on the next edge without settling
    repeat (5) cycle();
    inverse = 1'b0;
    cycle();
    check_bit("inverse_to_0_out", data_out, 1'b0);
    check_bit("inverse_to_0_settling", settling, 1'b0);
    inverse = 1'b1;
    cycle();
    check_bit("inverse_to_1_out", data_out, 1'b1);
    check_bit("inverse_to_1_settling", settling, 1'b0);

    // asynchronous reset while data_out=1 and settling=1
    data_in = 1'b1;
    repeat (5) cycle();
    set_delays(5, 0, 0);
    cycle();
    check_bit("pre_async_settling", settling, 1'b1);
    check_bit("pre_async_out", data_out, 1'b1);
    #2 g_rst = 1'b1;
    #1;
    model_reset();
    check_bit("async_reset_out", data_out, 1'b0);
    check_bit("async_reset_settling", settling, 1'b0);
    cycle();
    data_in = 1'b0;
    inverse = 1'b0;
    set_delays(0, 0, 0);
    g_rst = 1'b0;
    repeat (3) begin
      cycle();
      check_bit("post_reset_out_zero", data_out, 1'b0);
    end

    // vector table
    for (int v = 0; v < 6; v++) begin
      data_in = 1'b0;
      inverse = 1'b0;
      set_delays(int'(vecs[v].w), int'(vecs[v].r), int'(vecs[v].f));
      repeat (40) cycle();
      got = '0;
      for (int j = 0; j < 24; j++) begin
        data_in = (j < 16) ? vecs[v].pat[j] : 1'b0;
        cycle();
        got[j] = data_out;
      end
      checks++;
      if (got !== vecs[v].exp) begin
        failures++;
        $display("FAIL vec_%s: got %h expected %h", vecs[v].name, got, vecs[v].exp);
      end
    end

    // random stimulus, checked edge by edge against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) data_in = ~data_in;
      if ($urandom_range(0, 299) == 0)
        set_delays($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) inverse = ~inverse;
      g_rst = ($urandom_range(0, 699) == 0) ? 1'b1 : 1'b0;
      cycle();
    end
    g_rst = 1'b0;
    repeat (3) cycle();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
